// File: rtl/div_cu.sv
// Control unit for the restoring divider: Moore FSM sequencing load, the
// shift/subtract loop, the final remainder fix-up and the go/done handshake.
module div_cu #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       error,
    input  logic       r_lt_y,
    input  logic [3:0] cnt_out,
    output logic       ld_r,
    output logic       ld_x,
    output logic       ld_y,
    output logic       sl_r,
    output logic       sl_x,
    output logic       sr,
    output logic       right_in_x,
    output logic       sel1,
    output logic       sel2,
    output logic       ld_cnt,
    output logic       ce,
    output logic       ud,
    output logic [3:0] n,
    output logic       done,
    output logic       busy,
    output logic       err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_SHIFT0,
        S_TEST,
        S_SUB,
        S_SHL0,
        S_SHL1,
        S_ADJ,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_nxt;

    assign n = 4'(WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ld_r       = 1'b0;
        ld_x       = 1'b0;
        ld_y       = 1'b0;
        sl_r       = 1'b0;
        sl_x       = 1'b0;
        sr         = 1'b0;
        right_in_x = 1'b0;
        sel1       = 1'b0;
        sel2       = 1'b1;
        ld_cnt     = 1'b0;
        ce         = 1'b0;
        ud         = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        err        = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) state_nxt = error ? S_ERR : S_INIT;
            end
            S_INIT: begin
                busy      = 1'b1;
                ld_x      = 1'b1;
                ld_y      = 1'b1;
                ld_r      = 1'b1;
                sel1      = 1'b1;
                ld_cnt    = 1'b1;
                state_nxt = S_SHIFT0;
            end
            // Prime {R,X} with the first dividend bit; not counted as a loop pass.
            S_SHIFT0: begin
                busy      = 1'b1;
                sl_r      = 1'b1;
                sl_x      = 1'b1;
                state_nxt = S_TEST;
            end
            S_TEST: begin
                busy = 1'b1;
                if (cnt_out == 4'd0) state_nxt = S_ADJ;
                else if (r_lt_y)     state_nxt = S_SHL0;
                else                 state_nxt = S_SUB;
            end
            S_SUB: begin
                busy      = 1'b1;
                ld_r      = 1'b1;
                state_nxt = S_SHL1;
            end
            S_SHL0: begin
                busy      = 1'b1;
                sl_r      = 1'b1;
                sl_x      = 1'b1;
                ce        = 1'b1;
                state_nxt = S_TEST;
            end
            S_SHL1: begin
                busy       = 1'b1;
                sl_r       = 1'b1;
                sl_x       = 1'b1;
                right_in_x = 1'b1;
                ce         = 1'b1;
                state_nxt  = S_TEST;
            end
            // The last loop pass shifted R one place too far.
            S_ADJ: begin
                busy      = 1'b1;
                sr        = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                sel2 = 1'b0;
                done = 1'b1;
                if (!go) state_nxt = S_IDLE;
            end
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
                if (!go) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
